// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM
// encoding and the op-class / accumulate-mode enums.
package hilo_pkg;

    localparam logic [3:0] OP_MTHI  = 4'd0;
    localparam logic [3:0] OP_MTLO  = 4'd1;
    localparam logic [3:0] OP_MULT  = 4'd2;
    localparam logic [3:0] OP_MULTU = 4'd3;
    localparam logic [3:0] OP_DIV   = 4'd4;
    localparam logic [3:0] OP_DIVU  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    typedef enum logic {
        CLS_MUL = 1'b0,
        CLS_DIV = 1'b1
    } op_class_e;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_mode_e;

endpackage

// File: rtl/hilo_muldiv_unit_muldiv_iter_core.sv
// Iteration datapath: one shift-add multiply step or one restoring-divide
// step per enabled edge, operating on unsigned magnitudes.
module muldiv_iter_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  op_class_e        cls,
    input  logic [WIDTH-1:0] load_operand,
    input  logic [WIDTH-1:0] load_low,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] upper_q, upper_d;
    logic [WIDTH-1:0] lower_q, lower_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             ge;

    // Multiply keeps {upper,lower} as product-high / multiplier-shifting-out;
    // divide keeps {upper,lower} as remainder / dividend-becoming-quotient.
    always_comb begin
        operand_d = operand_q;
        upper_d   = upper_q;
        lower_d   = lower_q;
        sum       = {1'b0, upper_q} + (lower_q[0] ? {1'b0, operand_q} : '0);
        shifted   = {upper_q, lower_q[WIDTH-1]};
        ge        = shifted >= {1'b0, operand_q};
        if (load) begin
            operand_d = load_operand;
            upper_d   = '0;
            lower_d   = load_low;
        end else if (step) begin
            if (cls == CLS_MUL) begin
                upper_d = sum[WIDTH:1];
                lower_d = {sum[0], lower_q[WIDTH-1:1]};
            end else begin
                upper_d = WIDTH'(ge ? shifted - {1'b0, operand_q} : shifted);
                lower_d = {lower_q[WIDTH-2:0], ge};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_q <= '0;
            upper_q   <= '0;
            lower_q   <= '0;
        end else begin
            operand_q <= operand_d;
            upper_q   <= upper_d;
            lower_q   <= lower_d;
        end
    end

    assign res_hi = upper_q;
    assign res_lo = lower_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Architectural HI/LO registers with a multi-cycle multiply / divide /
// multiply-accumulate sequencer beside the EX stage.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_class_e        cls_q, cls_d;
    acc_mode_e        acc_q, acc_d;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, dbz_q, dbz_d;

    logic             is_signed, is_mul, is_div, in_neg_a, in_neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             core_load, core_step;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [2*WIDTH-1:0] prod_mag, prod_s;
    logic [WIDTH-1:0] quo_s, rem_s;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk          (Clk),
        .rst_n        (Reset),
        .load         (core_load),
        .step         (core_step),
        .cls          (cls_d),
        .load_operand (mag_b),
        .load_low     (mag_a),
        .res_hi       (core_hi),
        .res_lo       (core_lo)
    );

    // Operand decode: signed ops feed the core with magnitudes plus sign flags.
    always_comb begin
        is_signed = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
        is_div    = (Op == OP_DIV) || (Op == OP_DIVU);
        is_mul    = (Op == OP_MULT) || (Op == OP_MULTU) || (Op == OP_MADD) ||
                    (Op == OP_MADDU) || (Op == OP_MSUB) || (Op == OP_MSUBU);
        in_neg_a  = is_signed && A[WIDTH-1];
        in_neg_b  = is_signed && B[WIDTH-1];
        mag_a     = in_neg_a ? -A : A;
        mag_b     = in_neg_b ? -B : B;
    end

    always_comb begin
        prod_mag = {core_hi, core_lo};
        prod_s   = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
        quo_s    = (neg_a_q ^ neg_b_q) ? -core_lo : core_lo;
        rem_s    = neg_a_q ? -core_hi : core_hi;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cls_d     = cls_q;
        acc_d     = acc_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        b_zero_d  = b_zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Op == OP_MTHI) begin
                        hi_d = A;
                    end else if (Op == OP_MTLO) begin
                        lo_d = A;
                    end else if (is_mul || is_div) begin
                        cls_d     = is_div ? CLS_DIV : CLS_MUL;
                        acc_d     = ((Op == OP_MADD) || (Op == OP_MADDU)) ? ACC_ADD :
                                    ((Op == OP_MSUB) || (Op == OP_MSUBU)) ? ACC_SUB : ACC_NONE;
                        neg_a_d   = in_neg_a;
                        neg_b_d   = in_neg_b;
                        b_zero_d  = (B == '0);
                        cnt_d     = '0;
                        core_load = 1'b1;
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                core_step = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (cls_q == CLS_DIV) begin
                    if (b_zero_q) begin
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end
                end else begin
                    case (acc_q)
                        ACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                        ACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
                        default: {hi_d, lo_d} = prod_s;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cls_q    <= CLS_MUL;
            acc_q    <= ACC_NONE;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cls_q    <= cls_d;
            acc_q    <= acc_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            b_zero_q <= b_zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign Busy      = (state_q != ST_IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit at WIDTH=32; expected
// values are hand-computed constants.
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [3:0]   Op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic         DivByZero;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;

    int check_count = 0;
    int pass_count  = 0;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    // Issue one op for exactly one rising edge; returns on the following negedge.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clk);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic waitDone(output int busy_cycles, output bit got_done, output bit dbz);
        busy_cycles = 0;
        got_done    = 1'b0;
        dbz         = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (Done) begin
                got_done = 1'b1;
                dbz      = DivByZero;
                break;
            end
            if (Busy) busy_cycles++;
            @(negedge Clk);
        end
    endtask

    task automatic runLong(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input bit exp_dbz);
        int busy_cycles;
        bit got_done;
        bit dbz;
        applyStimulus(op, a, b);
        waitDone(busy_cycles, got_done, dbz);
        checkOutput({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
        checkOutput({tag, "_done"}, 64'(got_done), 64'd1);
        checkOutput({tag, "_busy_in_done"}, 64'(Busy), 64'd0);
        checkOutput({tag, "_dbz"}, 64'(dbz), 64'(exp_dbz));
        checkOutput({tag, "_hi"}, 64'(Hi), 64'(exp_hi));
        checkOutput({tag, "_lo"}, 64'(Lo), 64'(exp_lo));
        @(negedge Clk);
        checkOutput({tag, "_done_one_cycle"}, 64'(Done), 64'd0);
        checkOutput({tag, "_dbz_after"}, 64'(DivByZero), 64'd0);
    endtask

    initial begin
        int  busy_cycles;
        bit  got_done;
        bit  dbz;
        int  seen_done;

        Reset = 1'b0;
        Start = 1'b0;
        Op    = 4'd0;
        A     = '0;
        B     = '0;
        #1;
        checkOutput("rst_hi", 64'(Hi), 64'd0);
        checkOutput("rst_lo", 64'(Lo), 64'd0);
        checkOutput("rst_busy", 64'(Busy), 64'd0);
        checkOutput("rst_done", 64'(Done), 64'd0);
        checkOutput("rst_dbz", 64'(DivByZero), 64'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;

        applyStimulus(4'd0, 32'hFFFF_FFFF, 32'h0);
        checkOutput("mthi_hi", 64'(Hi), 64'hFFFF_FFFF);
        checkOutput("mthi_busy", 64'(Busy), 64'd0);
        checkOutput("mthi_done", 64'(Done), 64'd0);
        applyStimulus(4'd1, 32'h0000_0001, 32'h0);
        checkOutput("mtlo_lo", 64'(Lo), 64'h1);
        checkOutput("mtlo_hi", 64'(Hi), 64'hFFFF_FFFF);
        checkOutput("mtlo_busy", 64'(Busy), 64'd0);
        checkOutput("mtlo_done", 64'(Done), 64'd0);

        runLong("mult",  4'd2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        runLong("multu", 4'd3, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        runLong("div",   4'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        runLong("divu_zero", 4'd5, 32'h7, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        runLong("div_ovf", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        runLong("divu", 4'd5, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        applyStimulus(4'd0, 32'h0, 32'h0);
        applyStimulus(4'd1, 32'hFFFF_FFFF, 32'h0);
        runLong("madd", 4'd6, 32'h1, 32'h1, 32'h0000_0001, 32'h0000_0000, 1'b0);
        runLong("msub", 4'd8, 32'h1, 32'h1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);

        // MTHI issued while a multiply is running must be dropped, not queued.
        applyStimulus(4'd2, 32'd3, 32'd5);
        repeat (4) @(negedge Clk);
        Start = 1'b1;
        Op    = 4'd0;
        A     = 32'hDEAD_BEEF;
        @(negedge Clk);
        Start = 1'b0;
        checkOutput("ignore_hi_during", 64'(Hi), 64'h0);
        checkOutput("ignore_busy", 64'(Busy), 64'd1);
        waitDone(busy_cycles, got_done, dbz);
        checkOutput("ignore_done", 64'(got_done), 64'd1);
        checkOutput("ignore_hi", 64'(Hi), 64'h0);
        checkOutput("ignore_lo", 64'(Lo), 64'd15);
        @(negedge Clk);
        checkOutput("ignore_not_queued", 64'(Hi), 64'h0);

        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        checkOutput("async_rst_hi", 64'(Hi), 64'd0);
        checkOutput("async_rst_lo", 64'(Lo), 64'd0);
        checkOutput("async_rst_busy", 64'(Busy), 64'd0);
        checkOutput("async_rst_done", 64'(Done), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;

        applyStimulus(4'd1, 32'h1234_5678, 32'h0);
        applyStimulus(4'd4, 32'd100, 32'd7);
        repeat (9) @(negedge Clk);
        checkOutput("abort_busy_before", 64'(Busy), 64'd1);
        #2 Reset = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(Busy), 64'd0);
        checkOutput("abort_hi", 64'(Hi), 64'd0);
        checkOutput("abort_lo", 64'(Lo), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done) seen_done++;
        end
        checkOutput("abort_no_done", 64'(seen_done), 64'd0);
        checkOutput("abort_idle", 64'(Busy), 64'd0);

        runLong("mult_after", 4'd2, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised successor to the HI/LO register: holds the architectural HI and LO registers and sequences multi-cycle multiply, divide and multiply-accumulate into them.
- Sits beside the EX stage.
- Pipeline control issues an op with Start, stalls on Busy, and reads Hi/Lo for MFHI/MFLO.
- Moves (MTHI/MTLO) are single-cycle.

Parameters:
- WIDTH, 32: operand width and width of each of Hi and Lo.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  issue strobe; sampled on the rising edge of Clk.
- Op  in  4  operation code, sampled with Start.
- A  in  WIDTH  rs operand / move source.
- B  in  WIDTH  rt operand.
- Busy  out  1  multi-cycle op in progress.
- Done  out  1  one-cycle pulse; Hi/Lo hold the new result.
- DivByZero  out  1  valid with Done; divide had B==0.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Reset low, async:
  - Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, state=IDLE.
  - Any operation in flight is aborted and produces no Done.
- Op codes:
  - 0 MTHI, 1 MTLO, 2 MULT, 3 MULTU, 4 DIV, 5 DIVU, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU.
  - Codes 10-15: no action.
- Start is accepted only when state==IDLE. Start while Busy=1 is ignored entirely; the Op is not queued.
- MTHI/MTLO:
  - Hi (resp. Lo) <= A on the accepting edge.
  - Busy stays 0; Done is not pulsed.
- States: IDLE -> CALC -> FINISH -> IDLE.
- Accepting edge (edge 0):
  - Latch operands as magnitudes plus sign flags. Signed ops use two's complement; unsigned ops use raw values.
  - Latch the op class; cnt=0; go to CALC; Busy=1.
- CALC:
  - One iteration per edge: a shift-add multiply step or a restoring-divide step.
  - cnt increments each edge; after WIDTH iterations (edges 1..WIDTH) go to FINISH.
- FINISH, edge WIDTH+1:
  - Apply sign correction and commit Hi/Lo.
  - Busy=0, Done=1 for exactly one cycle; go to IDLE.
- Timing:
  - Busy is high WIDTH+1 cycles (33 at default).
  - New Hi/Lo are visible in the same cycle as Done.
  - A new Start may be accepted in the Done cycle.
- MULT/MULTU: {Hi,Lo} = full 2*WIDTH product.
- MADD/MADDU/MSUB/MSUBU:
  - {Hi,Lo} = {Hi,Lo} ± product, modulo 2^(2*WIDTH).
  - Hi/Lo cannot change during CALC, so the value at FINISH is the accumulator.
- DIV/DIVU:
  - Lo = quotient, Hi = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative / -1: Lo = most-negative (wrap), Hi = 0.
- Divide by zero:
  - Full latency still runs.
  - Hi/Lo are left unchanged; DivByZero=1 alongside Done.
  - DivByZero=0 at every other Done and in all non-Done cycles.

Decomposition:
- Shared package hilo_pkg:
  - Op code constants (OP_MTHI..OP_MSUBU).
  - State encoding: IDLE, CALC, FINISH.
  - Op-class enum: MUL, DIV.
- One sub-module, muldiv_iter_core:
  - Holds the iteration registers (partial product / remainder-quotient) and performs one step per enable.
  - The top level owns the FSM, counter, sign handling, accumulation and the Hi/Lo registers.

Test Plan (WIDTH=32):
- Reset pulse low mid-simulation -> Hi=0, Lo=0, Busy=0, Done=0 asynchronously, before the next Clk edge.
- MTHI A=FFFFFFFF, then MTLO A=00000001 -> after each edge Hi=FFFFFFFF, Lo=00000001; Busy never rises; no Done.
- MULT A=FFFFFFFF, B=00000002:
  - Busy high 33 cycles, then Done with Hi=FFFFFFFF, Lo=FFFFFFFE.
  - Repeat as MULTU -> Hi=00000001, Lo=FFFFFFFE.
- DIV A=FFFFFFF9, B=00000002 -> Lo=FFFFFFFD, Hi=FFFFFFFF.
- DIVU A=7, B=0 -> Done with DivByZero=1, Hi/Lo unchanged.
- Hi=0, Lo=FFFFFFFF; MADD A=1, B=1 -> Hi=00000001, Lo=00000000. Then MSUB A=1, B=1 -> Hi=00000000, Lo=FFFFFFFF.
- Start with MTHI during Busy -> ignored; Hi unchanged at Done.
- Reset low at cycle 10 of a DIV -> Busy=0, Hi=Lo=0, no Done pulse.
- A fresh MULT started afterwards completes normally.
